mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter SPLIT_WORDS, default 1: 1 = word accesses issued as four byte beats; 0 = word access issued as one word beat.
REQ-002 Parameter ADDR_W, default 18: address width, memory and CPU side.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  CPU request present.
REQ-006 req_ready  out  1  unit can accept a request this cycle.
REQ-007 req_write  in  1  1 = store (sw/sb), 0 = load (lw/lb/lbu).
REQ-008 req_byte  in  1  1 = byte access, 0 = word access.
REQ-009 req_signed  in  1  byte loads only: 1 = sign-extend (lb), 0 = zero-extend (lbu).
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  32  store data; byte store uses [7:0].
REQ-012 resp_valid  out  1  one-cycle completion pulse, loads and stores.
REQ-013 resp_rdata  out  32  load result, valid while resp_valid=1; 0 for stores.
REQ-014 mem_byteOperations  out  1  byte-wide memory beat.
REQ-015 mem_address  out  ADDR_W  memory beat address.
REQ-016 mem_write_data  out  32  memory beat write data.
REQ-017 mem_memRead  out  1  read beat strobe.
REQ-018 mem_memWrite  out  1  write beat strobe.
REQ-019 mem_read_data  in  32  combinational read data from memory, zero-extended in byte mode.

Function
REQ-020 FSM states IDLE, BEAT, RESP; req_ready=1 only in IDLE.
REQ-021 Request accepted on the edge where req_valid&&req_ready; all req_* fields latched then; IDLE->BEAT.
REQ-022 Beat count: byte access = 1; word access = 4 if SPLIT_WORDS=1, else 1.
REQ-023 Each beat lasts exactly one cycle, with exactly one of mem_memRead/mem_memWrite high.
REQ-024 Beat k (0..3) of a split word uses address (addr+k) mod 2^ADDR_W, byte lane = req_wdata[8k+7:8k] on mem_write_data[7:0], upper bits 0.
REQ-025 Little-endian: load beat k captures mem_read_data[7:0] into result[8k+7:8k] at the end of that beat.
REQ-026 Unsplit word beat: mem_byteOperations=0, full 32-bit data, mem_read_data captured whole.
REQ-027 Byte load result: bits [31:8] = replicated bit 7 if req_signed, else 0.
REQ-028 After last beat: BEAT->RESP; resp_valid=1 for exactly one cycle; RESP->IDLE.
REQ-029 Latency from accept edge to resp_valid: beats+1 cycles (byte = 2, split word = 5, unsplit word = 2).
REQ-030 No back-to-back overlap: next request accepted earliest in the cycle after RESP.
REQ-031 Outside BEAT: mem_memRead=0, mem_memWrite=0, mem_address/mem_write_data held at 0.
REQ-032 req_* changes after acceptance have no effect on the in-flight access.

Reset
REQ-033 rst_n low: state=IDLE, beat counter=0, result=0, resp_valid=0, resp_rdata=0, all mem_* outputs 0, req_ready=1 after release.
REQ-034 Reset mid-access aborts immediately; bytes already written remain; no resp_valid is issued for the aborted request.

Structure
REQ-035 Package mem_access_pkg holds the state enum (IDLE, BEAT, RESP) and the constant WORD_BEATS=4.
REQ-036 Single module; no sub-module required.

Verification
REQ-037 Split sw addr 0x00010, data 0xA1B2C3D4 -> four write beats at 0x10..0x13 carrying D4,C3,B2,A1; resp_valid 5 cycles after accept.
REQ-038 Split lw from 0x00010 after REQ-037 -> resp_rdata 0xA1B2C3D4.
REQ-039 lb from byte holding 0x80, req_signed=1 -> 0xFFFFFF80; same with req_signed=0 -> 0x00000080; latency 2.
REQ-040 Split sw at 0x3FFFE, data 0x11223344 -> beats at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-041 req_valid held high while busy -> req_ready=0, no second access until cycle after RESP.
REQ-042 rst_n low during beat 2 of a split sw -> strobes drop asynchronously, no resp_valid, FSM in IDLE, next request serviced normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the CPU-side memory access sequencer.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BEATS = 4;

endpackage

// File: rtl/mem_access_unit.sv
// Sequences CPU load/store requests into one or more memory beats and returns
// a single-cycle completion pulse with the assembled (sign/zero-extended) load data.
module mem_access_unit #(
    parameter int SPLIT_WORDS = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_byteOperations,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [31:0]       mem_read_data
);
    import mem_access_pkg::*;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       result_q, result_d;

    logic              split;
    logic              last_beat;
    logic [4:0]        lane;

    assign split     = !byte_q && (SPLIT_WORDS != 0);
    assign last_beat = !split || (cnt_q == 2'(WORD_BEATS - 1));
    assign lane      = {cnt_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = BEAT;
                    cnt_d    = '0;
                    write_d  = req_write;
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    result_d = '0;
                end
            end
            BEAT: begin
                if (!write_q) begin
                    if (byte_q) begin
                        result_d = signed_q ? {{24{mem_read_data[7]}}, mem_read_data[7:0]}
                                            : {24'h0, mem_read_data[7:0]};
                    end else if (split) begin
                        result_d[lane +: 8] = mem_read_data[7:0];
                    end else begin
                        result_d = mem_read_data;
                    end
                end
                if (last_beat) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

    // Memory-side outputs decode straight from state so an async reset drops the strobes at once.
    always_comb begin
        req_ready          = (state_q == IDLE);
        resp_valid         = (state_q == RESP);
        resp_rdata         = '0;
        mem_byteOperations = 1'b0;
        mem_address        = '0;
        mem_write_data     = '0;
        mem_memRead        = 1'b0;
        mem_memWrite       = 1'b0;
        if (state_q == RESP && !write_q) begin
            resp_rdata = result_q;
        end
        if (state_q == BEAT) begin
            mem_byteOperations = byte_q || split;
            mem_address        = addr_q + ADDR_W'(cnt_q);
            mem_memRead        = !write_q;
            mem_memWrite       = write_q;
            if (byte_q) begin
                mem_write_data = {24'h0, wdata_q[7:0]};
            end else if (split) begin
                mem_write_data = {24'h0, wdata_q[lane +: 8]};
            end else begin
                mem_write_data = wdata_q;
            end
        end
    end

endmodule
